// File: rtl/mdc_router_pkg.sv
// Shared types and helpers for the stream router.
package mdc_router_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    // Route-select width; a single input still needs one select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mdc_fwft_fifo.sv
// First-word fall-through FIFO, one per router output.
module mdc_fwft_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              last
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr;
    logic [AW-1:0]     r_rd;
    logic [AW:0]       r_cnt;
    logic              w_push_ok;
    logic              w_pop_ok;

    // Self-protecting: overflow/underflow requests are dropped here too.
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == (AW+1)'(DEPTH));
    // One word left: lets the router see "empty after this pop" a cycle early.
    assign last      = (r_cnt == (AW+1)'(1));
    // Head is forced to zero while empty so the port idles at a known value.
    assign dout      = empty ? '0 : r_mem[r_rd];

    // Storage array, no reset needed.
    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wr] <= din;
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            if (w_pop_ok)  r_rd <= r_rd + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mdc_stream_router.sv
// N_IN x N_OUT stream switch with per-output FWFT FIFOs, multicast fanout
// and drain-before-apply route reconfiguration.
module mdc_stream_router
    import mdc_router_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int N_OUT  = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int SEL_W  = sel_width(N_IN)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_IN*DATA_W-1:0]  in_data,
    input  logic [N_IN-1:0]         in_wr,
    output logic [N_IN-1:0]         in_full,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_rd,
    input  logic [N_OUT*SEL_W-1:0]  cfg_sel,
    input  logic [N_OUT-1:0]        cfg_en,
    input  logic                    cfg_req,
    output logic                    cfg_ack,
    output logic                    busy,
    output logic [N_IN-1:0]         ovf_err
);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [N_OUT-1:0][SEL_W-1:0]    r_sel_q;
    logic [N_OUT-1:0][SEL_W-1:0]    r_pend_sel;
    logic [N_OUT-1:0]               r_en_q;
    logic [N_OUT-1:0]               r_pend_en;
    logic [N_IN-1:0]                r_ovf;

    logic [N_OUT-1:0]               w_route_ok;
    logic [N_OUT-1:0]               w_push;
    logic [N_OUT-1:0]               w_pop;
    logic [N_OUT-1:0]               w_empty;
    logic [N_OUT-1:0]               w_full;
    logic [N_OUT-1:0]               w_last;
    logic [N_OUT-1:0][DATA_W-1:0]   w_din;
    logic [N_OUT-1:0][DATA_W-1:0]   w_dout;
    logic [N_IN-1:0][N_OUT-1:0]     w_fan;
    logic [N_IN-1:0]                w_full_in;
    logic [N_IN-1:0]                w_acc;
    logic                           w_run;
    logic                           w_drained;
    logic                           w_load;

    assign w_run = (r_state == ST_RUN);

    // Fanout sets and backpressure; everything here comes from registers,
    // so in_full never depends on in_wr in the same cycle.
    for (genvar o = 0; o < N_OUT; o++) begin : g_route
        assign w_route_ok[o] = r_en_q[o] && (int'(r_sel_q[o]) < N_IN);
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        for (genvar o = 0; o < N_OUT; o++) begin : g_fan
            assign w_fan[i][o] = w_route_ok[o] && (int'(r_sel_q[o]) == i);
        end
        assign w_full_in[i] = !w_run || ~|w_fan[i] || |(w_fan[i] & w_full);
        assign w_acc[i]     = in_wr[i] & ~w_full_in[i];
    end

    // Per-output source mux; an accepted write reaches its whole fanout at once.
    always_comb begin
        w_push = '0;
        w_din  = '0;
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (w_fan[i][o]) begin
                    w_push[o] = w_acc[i];
                    w_din[o]  = in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign w_pop = out_rd & ~w_empty;

    for (genvar o = 0; o < N_OUT; o++) begin : g_fifo
        mdc_fwft_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (w_push[o]),
            .pop   (w_pop[o]),
            .din   (w_din[o]),
            .dout  (w_dout[o]),
            .empty (w_empty[o]),
            .full  (w_full[o]),
            .last  (w_last[o])
        );
    end

    // Every FIFO is empty once this cycle's pops land (no pushes in DRAIN).
    assign w_drained = &(w_empty | (w_last & w_pop));

    // Next-state: RUN -> DRAIN on request, DRAIN -> APPLY once empty, APPLY -> RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_RUN:   if (cfg_req) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drained) w_state_nxt = ST_APPLY;
            ST_APPLY: begin
                w_load      = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // State, route registers, pending config and sticky overflow flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_sel_q    <= '0;
            r_en_q     <= '0;
            r_pend_sel <= '0;
            r_pend_en  <= '0;
            r_ovf      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_run && cfg_req) begin
                r_pend_sel <= cfg_sel;
                r_pend_en  <= cfg_en;
            end
            if (w_load) begin
                r_sel_q <= r_pend_sel;
                r_en_q  <= r_pend_en;
            end
            r_ovf <= r_ovf | (in_wr & w_full_in);
        end
    end

    assign in_full   = w_full_in;
    assign out_data  = w_dout;
    assign out_valid = ~w_empty;
    assign cfg_ack   = w_load;
    assign busy      = ~w_run;
    assign ovf_err   = r_ovf;

endmodule

// File: tb/tb_mdc_stream_router.sv
// Scoreboard bench for mdc_stream_router: expected tokens are queued per
// output at accept time and compared when the output pops them.
module tb_mdc_stream_router;
    localparam int N_IN = 3, N_OUT = 4, DATA_W = 32, DEPTH = 64, SEL_W = 2;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic [N_IN*DATA_W-1:0]  in_data = '0;
    logic [N_IN-1:0]         in_wr = '0;
    logic [N_IN-1:0]         in_full;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_rd = '0;
    logic [N_OUT*SEL_W-1:0]  cfg_sel = '0;
    logic [N_OUT-1:0]        cfg_en = '0;
    logic                    cfg_req = 1'b0;
    logic                    cfg_ack;
    logic                    busy;
    logic [N_IN-1:0]         ovf_err;

    int n_chk = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] sbq [N_OUT][$];
    int m_sel [N_OUT];
    logic [N_OUT-1:0] m_en = '0;
    int b_sel [N_OUT];
    logic [N_OUT-1:0] b_en = '0;

    mdc_stream_router #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_wr(in_wr),
        .in_full(in_full), .out_data(out_data), .out_valid(out_valid),
        .out_rd(out_rd), .cfg_sel(cfg_sel), .cfg_en(cfg_en), .cfg_req(cfg_req),
        .cfg_ack(cfg_ack), .busy(busy), .ovf_err(ovf_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: compare pops against queue heads, record accepted writes.
    always @(negedge clock) begin
        if (reset) begin
            for (int o = 0; o < N_OUT; o++) begin
                if (out_rd[o] && out_valid[o]) begin
                    if (sbq[o].size() == 0) chk($sformatf("underrun%0d", o), 1, 0);
                    else chk($sformatf("out%0d", o), out_data[o*DATA_W +: DATA_W], sbq[o].pop_front());
                end
            end
            for (int i = 0; i < N_IN; i++) begin
                if (in_wr[i] && !in_full[i])
                    for (int o = 0; o < N_OUT; o++)
                        if (m_en[o] && m_sel[o] == i) sbq[o].push_back(in_data[i*DATA_W +: DATA_W]);
            end
            if (cfg_ack) begin
                for (int o = 0; o < N_OUT; o++) m_sel[o] = b_sel[o];
                m_en = b_en;
            end
        end
    end

    task automatic req_cfg(input logic [7:0] sel, input logic [3:0] en);
        cfg_sel = sel;
        cfg_en  = en;
        cfg_req = 1'b1;
        for (int o = 0; o < N_OUT; o++) b_sel[o] = int'(sel[o*SEL_W +: SEL_W]);
        b_en = en;
        tick();
        cfg_req = 1'b0;
    endtask

    // Request a route with empty FIFOs; ack is due two cycles after cfg_req.
    task automatic cfg_apply(input string tag, input logic [7:0] sel, input logic [3:0] en);
        int n;
        req_cfg(sel, en);
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        while (!cfg_ack && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_ack_lat"}, n, 1);
        chk({tag, "_busy_apply"}, busy, 1);
        tick();
        chk({tag, "_run"}, busy, 0);
    endtask

    task automatic drain(input int o, input int n);
        out_rd[o] = 1'b1;
        repeat (n) tick();
        out_rd[o] = 1'b0;
    endtask

    initial begin
        int acc;
        logic seen;
        for (int o = 0; o < N_OUT; o++) begin m_sel[o] = 0; b_sel[o] = 0; end

        // Reset
        repeat (3) tick();
        chk("rst_full", in_full, 3'b111);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_ack", cfg_ack, 0);
        chk("rst_data", out_data, 0);
        reset = 1'b1;
        tick();
        in_data[0 +: DATA_W] = 32'hDEAD;
        in_wr = 3'b001;
        tick();
        in_wr = '0;
        chk("dead_ovf", ovf_err, 3'b001);
        tick();
        chk("dead_valid", out_valid, 0);

        // Unicast: out0<-0, out1<-1, out2<-2
        cfg_apply("uni", 8'h24, 4'b0111);
        chk("uni_full", in_full, 3'b000);
        in_data = {32'h33, 32'h22, 32'h11};
        in_wr = 3'b111;
        tick();
        in_wr = '0;
        chk("uni_valid", out_valid, 4'b0111);
        out_rd = 4'b0111;
        tick();
        out_rd = '0;
        chk("uni_empty", out_valid, 0);

        // Multicast in0 -> out0, out3; out3 never read until it fills
        cfg_apply("mc", 8'h00, 4'b1001);
        acc = 0;
        in_wr = 3'b001;
        out_rd = 4'b0001;
        for (int k = 0; k < 80; k++) begin
            in_data[0 +: DATA_W] = 32'h1000 + k;
            if (!in_full[0]) acc++;
            tick();
        end
        in_wr = '0;
        out_rd = '0;
        chk("mc_accepted", acc, DEPTH);
        chk("mc_block", in_full[0], 1);
        chk("mc_valid", out_valid, 4'b1000);
        chk("mc_q3", sbq[3].size(), DEPTH);
        drain(3, DEPTH);
        chk("mc_drained", out_valid, 0);

        // Full FIFO: push with simultaneous pop is blocked for one cycle
        cfg_apply("ff", 8'h04, 4'b0010);
        in_wr = 3'b010;
        for (int k = 0; k < DEPTH; k++) begin
            in_data[DATA_W +: DATA_W] = 32'h2000 + k;
            tick();
        end
        chk("ff_full", in_full[1], 1);
        in_data[DATA_W +: DATA_W] = 32'h20AA;
        out_rd = 4'b0010;
        chk("ff_blk", in_full[1], 1);
        tick();
        out_rd = '0;
        in_data[DATA_W +: DATA_W] = 32'h20BB;
        chk("ff_free", in_full[1], 0);
        tick();
        in_wr = '0;
        chk("ff_refull", in_full[1], 1);
        chk("ff_cnt", sbq[1].size(), DEPTH);
        chk("ff_ovf", ovf_err, 3'b011);
        drain(1, DEPTH);
        chk("ff_drained", out_valid, 0);

        // Reconfiguration with 5 tokens queued on out0
        cfg_apply("rc0", 8'h02, 4'b0001);
        in_wr = 3'b100;
        for (int k = 0; k < 5; k++) begin
            in_data[2*DATA_W +: DATA_W] = 32'h3100 + k;
            tick();
        end
        in_wr = '0;
        req_cfg(8'h01, 4'b0001);
        for (int k = 0; k < 3; k++) begin
            chk("rc_drain_full", in_full, 3'b111);
            chk("rc_hold_ack", cfg_ack, 0);
            tick();
        end
        out_rd = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            chk("rc_early_ack", cfg_ack, 0);
            tick();
        end
        out_rd = '0;
        chk("rc_ack", cfg_ack, 1);
        chk("rc_empty", out_valid, 0);
        tick();
        chk("rc_newfull", in_full, 3'b101);
        in_data = {32'h3002, 32'h3001, 32'h0};
        in_wr = 3'b110;
        tick();
        in_wr = '0;
        chk("rc_valid", out_valid, 4'b0001);
        drain(0, 1);
        chk("rc_done", out_valid, 0);

        // Out-of-range select keeps the output disabled
        cfg_apply("oob", 8'h30, 4'b0100);
        chk("oob_full", in_full, 3'b111);
        in_wr = 3'b111;
        tick();
        in_wr = '0;
        tick();
        chk("oob_valid", out_valid, 0);

        // Reset during DRAIN discards data and pending config
        cfg_apply("rd", 8'h00, 4'b0001);
        in_wr = 3'b001;
        repeat (3) tick();
        in_wr = '0;
        req_cfg(8'h00, 4'b0001);
        chk("rd_busy", busy, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int o = 0; o < N_OUT; o++) sbq[o].delete();
        m_en = '0;
        chk("rd_run", busy, 0);
        chk("rd_valid", out_valid, 0);
        chk("rd_ovf", ovf_err, 0);
        chk("rd_full", in_full, 3'b111);
        seen = 1'b0;
        repeat (6) begin
            seen = seen | cfg_ack;
            tick();
        end
        chk("rd_no_ack", seen, 0);

        for (int o = 0; o < N_OUT; o++) chk($sformatf("left%0d", o), sbq[o].size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
